ripple_count_capture: RTL

- Downstream consumer of the 4-bit ripple-carry counter output `q`.
- Ripple outputs change asynchronously to `clk`, and bits settle at staggered times. This block synchronizes the count and filters out transient intermediate values.
- Each settled new count value is queued into a small FIFO. Consumers read it through a valid/ready handshake, with overflow flagged.

---
 rtl/ripple_count_capture.sv | 113 +++++++++++
 1 files changed

// File: rtl/ripple_count_capture.sv
// Captures settled values of an asynchronous ripple counter: two-flop synchronizer,
// stability filter, and a small FIFO with valid/ready output and sticky overflow.
module ripple_count_capture #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int STABLE = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         cnt_in,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(STABLE) + 1;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [SW-1:0]    stab_q, stab_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic settle_push;
  logic full;
  logic pop;
  logic push;

  // Stability filter: a new sync2 value restarts the count; a settled value
  // differing from the last accepted one is offered to the FIFO exactly once.
  always_comb begin
    cand_d      = cand_q;
    stab_d      = stab_q;
    last_d      = last_q;
    settle_push = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      stab_d = '0;
    end else if (stab_q < SW'(STABLE - 1)) begin
      stab_d = stab_q + SW'(1);
    end else if (cand_q != last_q) begin
      settle_push = 1'b1;
      last_d      = cand_q;
    end
  end

  always_comb begin
    full       = (level_q == LW'(DEPTH));
    pop        = out_valid && out_ready;
    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    push       = settle_push && (!full || pop);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    overflow_d = overflow_q || (settle_push && full && !pop);
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_comb begin
        mem_d[gi] = mem_q[gi];
        if (push && (wr_ptr_q == AW'(gi))) begin
          mem_d[gi] = cand_q;
        end
      end

      always_ff @(posedge clk) begin
        mem_q[gi] <= mem_d[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cand_q     <= '0;
      last_q     <= '0;
      stab_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= cnt_in;
      sync2_q    <= sync1_q;
      cand_q     <= cand_d;
      last_q     <= last_d;
      stab_q     <= stab_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Memory contents survive reset, so the head is masked while empty.
  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule
